// File: rtl/dmac_master.sv
// dmac_master: DMA master engine of the DMAC.
// Pops (src, dest, size) descriptors from the slave's show-ahead FIFO and copies
// size 32-bit words over the shared bus as read/write pairs. It reports progress
// on status (00 idle, 01 busy, 10 done, 11 error).
// Optional feature: define DMAC_GRANT_TIMEOUT_EN to abandon the run and enter ERR
// when the bus grant does not arrive within TO_LIMIT cycles of requesting it.
// All outputs are registered. Each output is loaded on the edge that enters the
// state it belongs to.
module dmac_master #(
  parameter int TO_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic [1:0]  op_mode,
  input  logic        opdone_clear,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_src,
  input  logic [31:0] fifo_dest,
  input  logic [31:0] fifo_size,
  output logic        fifo_rd_en,
  output logic        m_req,
  input  logic        m_grant,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {
    IDLE, FETCH, REQ, RD, RD_WAIT, WR, DONE, ERR
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  state_t      state;
  logic [15:0] src;
  logic [15:0] dest;
  logic [4:0]  count;
  logic [31:0] data;
  // Set after popping a zero-size descriptor: the FIFO flag only reflects that
  // pop one cycle later, so FETCH waits a cycle before deciding what comes next.
  logic        skip_check;

  logic [4:0]  count_dec;
  logic [15:0] src_next;
  logic [15:0] dest_next;

  // The captured read word is driven straight onto the write data bus.
  assign m_dout = data;

  // Only the low address/size bits of a descriptor are meaningful.
  logic unused_desc_bits;
  assign unused_desc_bits = ^{fifo_src[31:16], fifo_dest[31:16], fifo_size[31:5]};

`ifdef DMAC_GRANT_TIMEOUT_EN
  localparam int TO_W = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_expired;
  // The grant has been missing for TO_LIMIT REQ cycles once this cycle ends.
  assign to_expired = (int'(to_cnt) >= TO_LIMIT - 1);
`else
  logic unused_to_limit;
  assign unused_to_limit = (TO_LIMIT != 0);
`endif

  // Count and address values committed by a WR cycle; op_mode is sampled here.
  always_comb begin
    count_dec = count - 5'd1;
    src_next  = src;
    dest_next = dest;
    case (op_mode)
      2'b00: begin
        src_next  = src + 16'd1;
        dest_next = dest + 16'd1;
      end
      2'b01: dest_next = dest + 16'd1;
      2'b10: src_next  = src + 16'd1;
      default: ;
    endcase
  end

  // Transfer sequencer; it computes the next state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      status     <= ST_IDLE;
      fifo_rd_en <= 1'b0;
      m_req      <= 1'b0;
      m_sel      <= 1'b0;
      m_wr       <= 1'b0;
      m_addr     <= 16'd0;
      data       <= 32'd0;
      src        <= 16'd0;
      dest       <= 16'd0;
      count      <= 5'd0;
      skip_check <= 1'b0;
`ifdef DMAC_GRANT_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      fifo_rd_en <= 1'b0;
      m_sel      <= 1'b0;
      m_wr       <= 1'b0;
      case (state)
        IDLE: begin
          if (op_start && !fifo_empty) begin
            state      <= FETCH;
            status     <= ST_BUSY;
            fifo_rd_en <= 1'b1;
            skip_check <= 1'b0;
          end
        end

        FETCH: begin
          if (skip_check) begin
            skip_check <= 1'b0;
            if (!fifo_empty) begin
              fifo_rd_en <= 1'b1;
            end else begin
              state  <= DONE;
              status <= ST_DONE;
            end
          end else begin
            src   <= fifo_src[15:0];
            dest  <= fifo_dest[15:0];
            count <= fifo_size[4:0];
            if (fifo_size[4:0] == 5'd0) begin
              skip_check <= 1'b1;
            end else begin
              state <= REQ;
              m_req <= 1'b1;
`ifdef DMAC_GRANT_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end

        REQ: begin
          if (m_grant) begin
            state  <= RD;
            m_sel  <= 1'b1;
            m_addr <= src;
          end
`ifdef DMAC_GRANT_TIMEOUT_EN
          else if (to_expired) begin
            state  <= ERR;
            status <= ST_ERR;
            m_req  <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        RD: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          state  <= WR;
          data   <= m_din;
          m_sel  <= 1'b1;
          m_wr   <= 1'b1;
          m_addr <= dest;
        end

        WR: begin
          count <= count_dec;
          src   <= src_next;
          dest  <= dest_next;
          if (count_dec != 5'd0) begin
            state  <= RD;
            m_sel  <= 1'b1;
            m_addr <= src_next;
          end else begin
            m_req <= 1'b0;
            if (!fifo_empty) begin
              state      <= FETCH;
              fifo_rd_en <= 1'b1;
              skip_check <= 1'b0;
            end else begin
              state  <= DONE;
              status <= ST_DONE;
            end
          end
        end

        DONE, ERR: begin
          if (opdone_clear) begin
            state  <= IDLE;
            status <= ST_IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          status <= ST_IDLE;
          m_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_master.sv
// tb_dmac_master: randomized self-checking bench for dmac_master.
// The bench models the descriptor FIFO and a registered bus target. It predicts
// the bus read/write trace for every job from the descriptor list with plain
// address arithmetic.
module tb_dmac_master;

  localparam int TO_LIMIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [1:0]  op_mode;
  logic        opdone_clear;
  logic        fifo_empty;
  logic [31:0] fifo_src;
  logic [31:0] fifo_dest;
  logic [31:0] fifo_size;
  logic        fifo_rd_en;
  logic        m_req;
  logic        m_grant;
  logic        m_sel;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din = 32'd0;
  logic [1:0]  status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmac_master #(.TO_LIMIT(TO_LIMIT)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_mode(op_mode),
    .opdone_clear(opdone_clear), .fifo_empty(fifo_empty), .fifo_src(fifo_src),
    .fifo_dest(fifo_dest), .fifo_size(fifo_size), .fifo_rd_en(fifo_rd_en),
    .m_req(m_req), .m_grant(m_grant), .m_sel(m_sel), .m_wr(m_wr),
    .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .status(status)
  );

  // Show-ahead descriptor FIFO model
  logic [31:0] q_src [0:63];
  logic [31:0] q_dest[0:63];
  logic [31:0] q_size[0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int pop_empty = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_src   = q_src[rd_ptr % 64];
  assign fifo_dest  = q_dest[rd_ptr % 64];
  assign fifo_size  = q_size[rd_ptr % 64];

  // FIFO pop side; popping an empty FIFO is recorded as a protocol violation
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (rd_ptr == wr_ptr) pop_empty <= pop_empty + 1;
      else rd_ptr <= rd_ptr + 1;
    end
  end

  // Registered bus target: read data depends on address and a per-job salt
  logic [15:0] salt = 16'h5a5a;
  function automatic logic [31:0] rdata(input logic [15:0] a);
    return {a ^ salt, ~a};
  endfunction

  always @(posedge clk) begin
    if (m_sel && !m_wr) m_din <= rdata(m_addr);
  end

  // Bus trace monitor, sampled mid-cycle
  logic [31:0] act_rd[$], act_wa[$], act_wd[$];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int cyc = 0;
  int first_rd = -1;
  int done_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_sel && !m_wr) begin
      act_rd.push_back(32'(m_addr));
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_sel && m_wr) begin
      act_wa.push_back(32'(m_addr));
      act_wd.push_back(m_dout);
    end
    if (status == 2'b10 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushDesc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    q_src[wr_ptr % 64]  = s;
    q_dest[wr_ptr % 64] = d;
    q_size[wr_ptr % 64] = z;
    wr_ptr = wr_ptr + 1;
  endtask

  // Predicts the bus trace of the queued descriptors from the address-mode rules
  task automatic prepExpect(input logic [1:0] mode);
    logic [15:0] s, d;
    int n, idx, words;
    bit src_inc, dest_inc;
    src_inc  = (mode == 2'b00) || (mode == 2'b10);
    dest_inc = (mode == 2'b00) || (mode == 2'b01);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    act_rd.delete(); act_wa.delete(); act_wd.delete();
    first_rd = -1;
    done_cyc = -1;
    n = wr_ptr - rd_ptr;
    for (int i = 0; i < n; i++) begin
      idx   = (rd_ptr + i) % 64;
      s     = q_src[idx][15:0];
      d     = q_dest[idx][15:0];
      words = int'(q_size[idx] % 32);
      for (int k = 0; k < words; k++) begin
        exp_rd.push_back(32'(s));
        exp_wa.push_back(32'(d));
        exp_wd.push_back(rdata(s));
        if (src_inc) s = s + 16'd1;
        if (dest_inc) d = d + 16'd1;
      end
    end
    op_mode = mode;
  endtask

  task automatic startJob();
    @(negedge clk);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic waitEnd(input string name);
    int t;
    t = 0;
    while (status != 2'b10 && status != 2'b11 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput({name, "_finished"}, (t < 3000) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic checkLogs(input string name);
    checkOutput({name, "_nreads"}, act_rd.size(), exp_rd.size());
    checkOutput({name, "_nwrites"}, act_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_rd.size() && i < act_rd.size(); i++)
      checkOutput($sformatf("%s_rd%0d", name, i), act_rd[i], exp_rd[i]);
    for (int i = 0; i < exp_wa.size() && i < act_wa.size(); i++) begin
      checkOutput($sformatf("%s_wa%0d", name, i), act_wa[i], exp_wa[i]);
      checkOutput($sformatf("%s_wd%0d", name, i), act_wd[i], exp_wd[i]);
    end
  endtask

  task automatic clearDone(input string name);
    opdone_clear = 1'b1;
    @(negedge clk);
    opdone_clear = 1'b0;
    checkOutput({name, "_cleared"}, 32'(status), 0);
  endtask

  // Full job: predict, start, wait for DONE, compare trace, pops and status
  task automatic applyStimulus(input logic [1:0] mode, input string name);
    int n, p0;
    n  = wr_ptr - rd_ptr;
    p0 = pops;
    prepExpect(mode);
    startJob();
    waitEnd(name);
    checkOutput({name, "_status"}, 32'(status), 2);
    checkOutput({name, "_req_low"}, 32'(m_req), 0);
    checkOutput({name, "_pops"}, pops - p0, n);
    checkLogs(name);
    clearDone(name);
  endtask

  initial begin
    int t, p0, nd, errc, reqc, bad;
    logic [31:0] sz;
    reset = 1'b1; op_start = 1'b0; op_mode = 2'b00; opdone_clear = 1'b0; m_grant = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_status", 32'(status), 0);
    checkOutput("rst_req", 32'(m_req), 0);
    checkOutput("rst_sel", 32'(m_sel), 0);
    checkOutput("rst_wr", 32'(m_wr), 0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 0);
    checkOutput("rst_addr", 32'(m_addr), 0);
    checkOutput("rst_dout", m_dout, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty start: nothing happens
    prepExpect(2'b00);
    p0 = pops;
    op_start = 1'b1;
    repeat (5) @(negedge clk);
    op_start = 1'b0;
    checkOutput("empty_status", 32'(status), 0);
    checkOutput("empty_pops", pops - p0, 0);
    checkOutput("empty_bus", act_rd.size() + act_wa.size(), 0);

    // Basic copy with cycle count from first RD to DONE
    salt = 16'h1234;
    pushDesc(32'h0000_0010, 32'h0000_0020, 32'd3);
    applyStimulus(2'b00, "basic");
    checkOutput("basic_cycles", done_cyc - first_rd, 9);

    // Fixed source, destination wraps past 0xFFFF
    salt = 16'hbeef;
    pushDesc(32'h0000_0040, 32'h0000_ffff, 32'd2);
    applyStimulus(2'b01, "wrap");

    // Chained descriptors including a zero-size one, upper bits set
    salt = 16'h0f0f;
    pushDesc(32'hffff_0100, 32'habcd_0200, 32'hffff_ffe2);
    pushDesc(32'h0000_0300, 32'h0000_0400, 32'h0000_0020);
    pushDesc(32'h1234_0500, 32'h0000_0600, 32'd1);
    applyStimulus(2'b00, "chain");

    // Trailing zero-size descriptor ends the run in DONE
    pushDesc(32'h0000_0700, 32'h0000_0800, 32'd1);
    pushDesc(32'h0000_0900, 32'h0000_0a00, 32'd0);
    applyStimulus(2'b10, "tailzero");

    // Grant stall
    salt = 16'h7777;
    pushDesc(32'h0000_1000, 32'h0000_2000, 32'd2);
    pushDesc(32'h0000_3000, 32'h0000_4000, 32'd1);
    m_grant = 1'b0;
    prepExpect(2'b00);
    p0 = pops;
    startJob();
`ifdef DMAC_GRANT_TIMEOUT_EN
    t = 0; reqc = 0; errc = -1;
    while (t < 40 && errc < 0) begin
      if (m_req) reqc++;
      if (status == 2'b11) errc = t;
      @(negedge clk);
      t++;
    end
    checkOutput("stall_err_reached", (errc >= 0) ? 1 : 0, 1);
    checkOutput("stall_req_cycles", reqc, TO_LIMIT);
    checkOutput("stall_status", 32'(status), 3);
    checkOutput("stall_req_low", 32'(m_req), 0);
    checkOutput("stall_pops", pops - p0, 1);
    checkOutput("stall_no_bus", act_rd.size(), 0);
    m_grant = 1'b1;
    clearDone("stall");
    wr_ptr = rd_ptr;
`else
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (status != 2'b01) bad++;
      @(negedge clk);
    end
    checkOutput("stall_busy", bad, 0);
    checkOutput("stall_req", 32'(m_req), 1);
    checkOutput("stall_no_bus", act_rd.size(), 0);
    m_grant = 1'b1;
    waitEnd("stall");
    checkOutput("stall_status", 32'(status), 2);
    checkOutput("stall_pops", pops - p0, 2);
    checkLogs("stall");
    clearDone("stall");
`endif

    // Reset during WR of a 4-word transfer
    pushDesc(32'h0000_0100, 32'h0000_0200, 32'd4);
    pushDesc(32'h0000_0500, 32'h0000_0600, 32'd2);
    prepExpect(2'b00);
    startJob();
    t = 0;
    while (!(m_sel && m_wr) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rst_reach_wr", (t < 200) ? 1 : 0, 1);
    reset = 1'b1;
    p0 = pops;
    @(negedge clk);
    checkOutput("midrst_status", 32'(status), 0);
    checkOutput("midrst_req", 32'(m_req), 0);
    checkOutput("midrst_sel", 32'(m_sel), 0);
    checkOutput("midrst_wr", 32'(m_wr), 0);
    checkOutput("midrst_addr", 32'(m_addr), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midrst_no_pop", pops - p0, 0);
    checkOutput("midrst_idle", 32'(status), 0);
    wr_ptr = rd_ptr;

    // Randomized jobs
    for (int it = 0; it < 10; it++) begin
      salt = 16'($urandom);
      nd = $urandom_range(1, 4);
      for (int j = 0; j < nd; j++) begin
        sz = $urandom;
        sz[4:0] = 5'($urandom_range(0, 5));
        pushDesc($urandom, $urandom, sz);
      end
      applyStimulus(2'($urandom_range(0, 3)), $sformatf("rand%0d", it));
    end

    checkOutput("pop_while_empty", pop_empty, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmac_master.md
# dmac_master

DMA master engine of the DMAC. Consumes the control outputs of the DMAC slave register block (`op_start`, `op_mode`, `opdone_clear`) and pops transfer descriptors (source, destination, size) from the descriptor FIFO the slave writes into. Executes word-by-word read/write transfers on the shared bus, then reports `status` back to the slave for its status and interrupt registers.

## Interface
- `TO_LIMIT`, 16: grant-timeout cycle count; used only with `DMAC_GRANT_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op_start` in 1: level; run request from the slave.
- `op_mode` in 2: address mode. 00: src inc, dest inc. 01: src fixed, dest inc. 10: src inc, dest fixed. 11: both fixed.
- `opdone_clear` in 1: acknowledges DONE/ERR.
- `fifo_empty` in 1: descriptor FIFO empty.
- `fifo_src`, `fifo_dest`, `fifo_size` in 32 each: FIFO head descriptor (show-ahead); valid while `!fifo_empty`.
- `fifo_rd_en` out 1: one-cycle pop strobe.
- `m_req` out 1: bus request.
- `m_grant` in 1: bus grant.
- `m_sel` out 1, `m_wr` out 1: bus select and write.
- `m_addr` out 16: bus address.
- `m_dout` out 32: write data.
- `m_din` in 32: read data; registered by the target and valid one cycle after the read cycle.
- `status` out 2: 00 idle, 01 busy, 10 done, 11 error.

## Operation
- States: IDLE, FETCH, REQ, RD, RD_WAIT, WR, DONE, ERR.
- Reset: state IDLE; all outputs 0. This includes `status`=00, `fifo_rd_en`, `m_req`, `m_sel`, `m_wr`, `m_addr` and `m_dout`. The internal src, dest, count and data registers are also cleared to 0.
- IDLE: if `op_start`=1 and `fifo_empty`=0, go to FETCH. If `op_start`=1 and the FIFO is empty, stay in IDLE with `status`=00.
- FETCH:
  - Drive `fifo_rd_en`=1 for exactly one cycle.
  - Latch `src`=`fifo_src[15:0]`, `dest`=`fifo_dest[15:0]`, `count`=`fifo_size[4:0]`. Upper bits are ignored.
  - If `count`=0, the descriptor is skipped: go to FETCH if the FIFO is still non-empty after the pop, otherwise to DONE.
  - If `count`≠0, go to REQ.
- REQ: `m_req`=1. Wait for `m_grant`=1, then go to RD. `m_req` stays 1 until the last WR of the descriptor completes.
- RD: `m_sel`=1, `m_wr`=0, `m_addr`=src; go to RD_WAIT.
- RD_WAIT: `m_sel`=0; capture `m_din` into the data register at the end of the cycle; go to WR.
- WR: `m_sel`=1, `m_wr`=1, `m_addr`=dest, `m_dout`=data. Then:
  - Decrement `count`.
  - Update src and dest per `op_mode`; increments are +1 with 16-bit wrap, 0xFFFF→0x0000.
  - If `count` is now nonzero, go to RD.
  - Else drop `m_req`, then go to FETCH if `fifo_empty`=0, otherwise to DONE.
- `op_mode` is sampled every WR cycle. Software must not change it while busy; a change mid-run takes effect on the next address update.
- DONE: `status`=10, hold until `opdone_clear`=1, then go to IDLE.
- ERR: `status`=11, hold until `opdone_clear`=1, then go to IDLE.
- `status`=01 in FETCH, REQ, RD, RD_WAIT and WR.
- `op_start` deasserting mid-run has no effect. The current FIFO contents are drained.
- Reset mid-transfer: the descriptor is abandoned and all outputs return to their reset values next cycle. The FIFO is not popped.

## Timing
- IDLE→FETCH: 1 cycle after `op_start`.
- FETCH→REQ: 1 cycle.
- REQ→RD: 1 cycle after `m_grant` is sampled high.
- Per word: 3 cycles (RD, RD_WAIT, WR). An N-word descriptor takes 3N cycles after grant.
- Outputs are registered and change only on the clock edge after the state transition.
- `fifo_rd_en` is never asserted while `fifo_empty`=1.
- DONE→IDLE: 1 cycle after `opdone_clear`. `status` reads 00 in that cycle.

## Configuration
- `DMAC_GRANT_TIMEOUT_EN` defined:
  - A counter runs in REQ. It clears on entering REQ.
  - If `m_grant` is still 0 after `TO_LIMIT` cycles, drop `m_req` and go to ERR.
  - Remaining FIFO descriptors are left unpopped.
- Undefined: REQ waits indefinitely, no counter logic is built, and `status`=11 never occurs.

## Test plan
- Reset: assert `reset` during WR of a 4-word transfer → next cycle `status`=00, `m_req`=0, `m_sel`=0, no further `fifo_rd_en`.
- Basic copy: descriptor src=0x0010, dest=0x0020, size=3, mode 00, grant tied high → reads at 0x10, 0x11, 0x12 and writes of the returned data to 0x20, 0x21, 0x22. Exactly 9 bus cycles after RD start, then `status`=10.
- Mode and wrap: mode 01 with src=0x0040, dest=0xFFFF, size=2 → reads 0x40 twice, writes 0xFFFF then 0x0000.
- Chained descriptors: 2 descriptors (size 2, then size 0) then a 3rd (size 1) queued → 3 pops, 3 words moved, one DONE. `opdone_clear` pulse → IDLE.
- Grant stall: hold `m_grant`=0 for 20 cycles → with macro, ERR at cycle `TO_LIMIT`=16 and `status`=11. Without macro, `status`=01 throughout and the transfer proceeds once grant rises.
- Empty start: `op_start`=1 with `fifo_empty`=1 → stays IDLE, `status`=00, no `fifo_rd_en`.
